hazard_ctrl: RTL and testbench

- Pipeline hazard and stall scheduler for the 5-stage core. Drives the stall and flush controls of the PC, IF/ID, ID/EX and EX/MEM registers.
- Detects load-use hazards, resolves taken branches (in EX) and jumps (in ID) by flushing, and sequences multi-cycle mult/div ops.
- A mult/div op occupies EX for MULDIV_CYCLES cycles. During that time the front end is frozen and bubbles are fed into MEM.

---
 rtl/hazard_ctrl_if.sv | 32 +++
 rtl/hazard_ctrl.sv | 124 ++++++++++++
 tb/tb_hazard_ctrl.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath (master) and hazard_ctrl (slave).
// Carries the EX/ID hazard sources and the stall/flush controls for PC, IF/ID, ID/EX and EX/MEM.
interface hazard_ctrl_if;
  logic       EX_MemRead;
  logic [4:0] EX_RegWrAddr;
  logic       EX_BranchTaken;
  logic [4:0] ID_RegRs;
  logic [4:0] ID_RegRt;
  logic       ID_UsesRt;
  logic       ID_Jump;
  logic       ID_MulDiv;

  logic       PC_stall;
  logic       IF_stall;
  logic       IF_flush;
  logic       ID_stall;
  logic       ID_flush;
  logic       EX_bubble;
  logic       EX_busy;

  modport master (
    output EX_MemRead, EX_RegWrAddr, EX_BranchTaken,
    output ID_RegRs, ID_RegRt, ID_UsesRt, ID_Jump, ID_MulDiv,
    input  PC_stall, IF_stall, IF_flush, ID_stall, ID_flush, EX_bubble, EX_busy
  );

  modport slave (
    input  EX_MemRead, EX_RegWrAddr, EX_BranchTaken,
    input  ID_RegRs, ID_RegRt, ID_UsesRt, ID_Jump, ID_MulDiv,
    output PC_stall, IF_stall, IF_flush, ID_stall, ID_flush, EX_bubble, EX_busy
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Load-use / branch / jump hazard scheduler with a multi-cycle mult/div sequencer for the 5-stage core.
// Optional HAZARD_PERF_CNT_EN adds saturating stall_cycles / flush_events counters.
module hazard_ctrl #(
  parameter int MULDIV_CYCLES = 4,
  parameter int CNT_W         = 3
) (
  input  logic        clk,
  input  logic        reset,
  hazard_ctrl_if.slave hz
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_events
`endif
);

  typedef enum logic {ST_RUN, ST_MULDIV} state_t;

  localparam bit             MD_EN   = (MULDIV_CYCLES > 1);
  localparam logic [CNT_W-1:0] MD_LOAD = CNT_W'(MULDIV_CYCLES - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;

  logic w_lu;
  logic w_md_start;
  logic w_pc_stall, w_if_stall, w_if_flush, w_id_stall, w_id_flush, w_ex_bubble, w_ex_busy;

  assign w_lu = hz.EX_MemRead && (hz.EX_RegWrAddr != 5'd0) &&
                ((hz.EX_RegWrAddr == hz.ID_RegRs) ||
                 (hz.ID_UsesRt && (hz.EX_RegWrAddr == hz.ID_RegRt)));

  // A mult/div only launches when nothing of higher priority claims the cycle.
  assign w_md_start = MD_EN && (r_state == ST_RUN) && hz.ID_MulDiv &&
                      !hz.EX_BranchTaken && !w_lu && !hz.ID_Jump;

  // NOTE: every output gets a default before the branches so no latch can be inferred.
  always_comb begin
    w_pc_stall  = 1'b0;
    w_if_stall  = 1'b0;
    w_if_flush  = 1'b0;
    w_id_stall  = 1'b0;
    w_id_flush  = 1'b0;
    w_ex_bubble = 1'b0;
    w_ex_busy   = 1'b0;
    if (reset) begin
      if (r_state == ST_MULDIV) begin
        w_ex_busy   = 1'b1;
        w_pc_stall  = 1'b1;
        w_if_stall  = 1'b1;
        w_id_stall  = 1'b1;
        w_ex_bubble = 1'b1;
      end else if (hz.EX_BranchTaken) begin
        w_if_flush = 1'b1;
        w_id_flush = 1'b1;
      end else if (w_lu) begin
        w_pc_stall = 1'b1;
        w_if_stall = 1'b1;
        w_id_flush = 1'b1;
      end else if (hz.ID_Jump) begin
        w_if_flush = 1'b1;
      end
    end
  end

  assign hz.PC_stall  = w_pc_stall;
  assign hz.IF_stall  = w_if_stall;
  assign hz.IF_flush  = w_if_flush;
  assign hz.ID_stall  = w_id_stall;
  assign hz.ID_flush  = w_id_flush;
  assign hz.EX_bubble = w_ex_bubble;
  assign hz.EX_busy   = w_ex_busy;

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_RUN;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_md_start) begin
            r_state <= ST_MULDIV;
            r_cnt   <= MD_LOAD;
          end
        end
        ST_MULDIV: begin
          // Leaving on cnt<=1 rather than ==1 keeps the counter from ever wrapping.
          if (r_cnt <= CNT_W'(1)) begin
            r_state <= ST_RUN;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: begin
          r_state <= ST_RUN;
          r_cnt   <= '0;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_flush_events;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cycles <= '0;
      r_flush_events <= '0;
    end else begin
      if (w_pc_stall && (r_stall_cycles != 32'hFFFF_FFFF))
        r_stall_cycles <= r_stall_cycles + 32'd1;
      if ((w_if_flush || w_id_flush) && (r_flush_events != 32'hFFFF_FFFF))
        r_flush_events <= r_flush_events + 32'd1;
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign flush_events = r_flush_events;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed literal cases plus randomized traffic against a behavioural model.
// Control vector order: {PC_stall, IF_stall, IF_flush, ID_stall, ID_flush, EX_bubble, EX_busy}.
module tb_hazard_ctrl;
  localparam int MDC = 4;

  localparam logic [6:0] C_IDLE = 7'b0000000;
  localparam logic [6:0] C_LU   = 7'b1100100;
  localparam logic [6:0] C_BR   = 7'b0010100;
  localparam logic [6:0] C_JMP  = 7'b0010000;
  localparam logic [6:0] C_BUSY = 7'b1101011;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_err = 0;
  int   n_checks = 0;

  hazard_ctrl_if hz();

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_events;
  longint m_stall = 0, m_flush = 0;
`endif

  hazard_ctrl #(.MULDIV_CYCLES(MDC), .CNT_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cycles (stall_cycles),
    .flush_events (flush_events)
`endif
  );

  always #5 clk = ~clk;

  logic [6:0] ctl;
  assign ctl = {hz.PC_stall, hz.IF_stall, hz.IF_flush, hz.ID_stall,
                hz.ID_flush, hz.EX_bubble, hz.EX_busy};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: remaining busy cycles of the current mult/div, outputs from the priority rules.
  int md_left = 0;

  function automatic logic model_lu();
    return hz.EX_MemRead && hz.EX_RegWrAddr != 0 &&
           (hz.EX_RegWrAddr == hz.ID_RegRs || (hz.ID_UsesRt && hz.EX_RegWrAddr == hz.ID_RegRt));
  endfunction

  function automatic logic [6:0] model_ctl();
    if (!reset)            return C_IDLE;
    if (md_left > 0)       return C_BUSY;
    if (hz.EX_BranchTaken) return C_BR;
    if (model_lu())        return C_LU;
    if (hz.ID_Jump)        return C_JMP;
    return C_IDLE;
  endfunction

  always @(posedge clk) begin
    logic [6:0] m;
    m = model_ctl();
`ifdef HAZARD_PERF_CNT_EN
    if (!reset) begin
      m_stall = 0;
      m_flush = 0;
    end else begin
      if (m[6] && m_stall < 64'hFFFF_FFFF) m_stall++;
      if ((m[4] || m[2]) && m_flush < 64'hFFFF_FFFF) m_flush++;
    end
`endif
    if (!reset)
      md_left = 0;
    else if (md_left > 0)
      md_left--;
    else if (!hz.EX_BranchTaken && !model_lu() && !hz.ID_Jump && hz.ID_MulDiv && MDC > 1)
      md_left = MDC - 1;
  end

  // Single compare process: every cycle, mid-way between the input change and the next edge.
  always @(negedge clk) begin
    #2;
    check("ctl_vs_model", 32'(ctl), 32'(model_ctl()));
    check("inv_id_stall_flush", 32'(hz.ID_stall & hz.ID_flush), 32'd0);
    check("inv_if_stall_flush", 32'(hz.IF_stall & hz.IF_flush), 32'd0);
`ifdef HAZARD_PERF_CNT_EN
    check("stall_cycles_vs_model", stall_cycles, 32'(m_stall));
    check("flush_events_vs_model", flush_events, 32'(m_flush));
`endif
  end

  task automatic drive(input logic mr, input logic [4:0] wa, input logic br,
                       input logic [4:0] rs, input logic [4:0] rt, input logic ut,
                       input logic jp, input logic md);
    @(negedge clk);
    hz.EX_MemRead = mr; hz.EX_RegWrAddr = wa; hz.EX_BranchTaken = br;
    hz.ID_RegRs = rs; hz.ID_RegRt = rt; hz.ID_UsesRt = ut;
    hz.ID_Jump = jp; hz.ID_MulDiv = md;
    #2;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset held with a branch present: outputs must still be forced low.
    hz.EX_MemRead = 1'b1; hz.EX_RegWrAddr = 5'd5; hz.EX_BranchTaken = 1'b1;
    hz.ID_RegRs = 5'd5; hz.ID_RegRt = 5'd0; hz.ID_UsesRt = 1'b0;
    hz.ID_Jump = 1'b1; hz.ID_MulDiv = 1'b0;
    #2;
    check("reset_outputs_zero", 32'(ctl), 32'(C_IDLE));
    @(negedge clk); reset = 1'b1;
    idle();
    check("idle_after_reset", 32'(ctl), 32'(C_IDLE));

    // Load-use on rs, one bubble, then clean.
    drive(1'b1, 5'd5, 1'b0, 5'd5, 5'd1, 1'b0, 1'b0, 1'b0);
    check("lu_rs", 32'(ctl), 32'(C_LU));
    drive(1'b0, 5'd5, 1'b0, 5'd5, 5'd1, 1'b0, 1'b0, 1'b0);
    check("lu_rs_replay", 32'(ctl), 32'(C_IDLE));

    // Load into $zero, rt match without rt use, rt match with rt use.
    drive(1'b1, 5'd0, 1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    check("lu_zero_reg", 32'(ctl), 32'(C_IDLE));
    drive(1'b1, 5'd8, 1'b0, 5'd3, 5'd8, 1'b0, 1'b0, 1'b0);
    check("rt_match_unused", 32'(ctl), 32'(C_IDLE));
    drive(1'b1, 5'd8, 1'b0, 5'd3, 5'd8, 1'b1, 1'b0, 1'b0);
    check("lu_rt", 32'(ctl), 32'(C_LU));

    // Branch beats load-use; jump alone; jump behind a load-use.
    drive(1'b1, 5'd5, 1'b1, 5'd5, 5'd0, 1'b0, 1'b1, 1'b1);
    check("branch_over_lu", 32'(ctl), 32'(C_BR));
    drive(1'b0, 5'd0, 1'b0, 5'd1, 5'd2, 1'b0, 1'b1, 1'b0);
    check("jump", 32'(ctl), 32'(C_JMP));
    drive(1'b1, 5'd7, 1'b0, 5'd7, 5'd0, 1'b0, 1'b1, 1'b0);
    check("jump_lu_stall", 32'(ctl), 32'(C_LU));
    drive(1'b0, 5'd7, 1'b0, 5'd7, 5'd0, 1'b0, 1'b1, 1'b0);
    check("jump_replay", 32'(ctl), 32'(C_JMP));

    // Mult/div: launch cycle is clean, then 3 busy cycles ignoring a branch, then RUN.
    drive(1'b0, 5'd0, 1'b0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b1);
    check("md_launch", 32'(ctl), 32'(C_IDLE));
    for (int i = 0; i < MDC - 1; i++) begin
      drive(1'b1, 5'd1, 1'b1, 5'd1, 5'd1, 1'b1, 1'b1, 1'b0);
      check("md_busy", 32'(ctl), 32'(C_BUSY));
    end
    idle();
    check("md_done", 32'(ctl), 32'(C_IDLE));

    // Back-to-back mult/div: the second one launches on the first RUN cycle.
    drive(1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < MDC - 1; i++) drive(1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    check("md_b2b_launch", 32'(ctl), 32'(C_IDLE));
    idle();
    check("md_b2b_busy", 32'(ctl), 32'(C_BUSY));
    for (int i = 0; i < MDC - 2; i++) idle();
    idle();

    // Reset on the second busy cycle abandons the sequence.
    drive(1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    idle();
    check("md_rst_busy1", 32'(ctl), 32'(C_BUSY));
    @(negedge clk); reset = 1'b0; #2;
    check("md_rst_forced", 32'(ctl), 32'(C_IDLE));
    @(negedge clk); reset = 1'b1; #2;
    check("md_rst_run", 32'(ctl), 32'(C_IDLE));
    idle();
    check("md_rst_run2", 32'(ctl), 32'(C_IDLE));

`ifdef HAZARD_PERF_CNT_EN
    @(negedge clk); reset = 1'b0;
    @(negedge clk); reset = 1'b1;
    drive(1'b1, 5'd5, 1'b0, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < MDC; i++) idle();
    check("perf_stall_cycles", stall_cycles, 32'd4);
    check("perf_flush_events", flush_events, 32'd1);
`endif

    // Randomized traffic, small register range to provoke matches, occasional resets.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 99) != 0);
      hz.EX_MemRead     = $urandom_range(0, 1);
      hz.EX_RegWrAddr   = 5'($urandom_range(0, 3));
      hz.EX_BranchTaken = ($urandom_range(0, 7) == 0);
      hz.ID_RegRs       = 5'($urandom_range(0, 3));
      hz.ID_RegRt       = 5'($urandom_range(0, 3));
      hz.ID_UsesRt      = $urandom_range(0, 1);
      hz.ID_Jump        = ($urandom_range(0, 7) == 0);
      hz.ID_MulDiv      = ($urandom_range(0, 5) == 0);
    end
    @(negedge clk); reset = 1'b1;
    idle();
    idle();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
